ext_pipe: RTL and testbench

- Parametrised successor to the datapath immediate extender.
- Adds load-data byte/halfword extension with address-offset select, an error flag, and a DEPTH-stage elastic pipeline with valid/ready handshake, flush and occupancy count.
- Sits between the operand/load-data source and the writeback mux, and absorbs backpressure from a stalled consumer.

---
 rtl/ext_pipe.sv | 135 +++++++++++++
 tb/tb_ext_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// Immediate and load-data extender feeding a DEPTH-stage elastic valid/ready pipeline.
// Latency DEPTH cycles; ready chain is combinational so a stalled consumer backs up to in_ready.
module ext_pipe #(
  parameter  int DATA_W = 32,
  parameter  int IMM_W  = 16,
  parameter  int DEPTH  = 2,
  parameter  int TAG_W  = 5,
  localparam int OFF_W  = $clog2(DATA_W / 8),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [2:0] {
    OP_ZERO, OP_SIGNED, OP_LUI, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_RSVD
  } op_e;

  logic [OFF_W+2:0]  sh_b, sh_h;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] ext_dat;
  logic              ext_err;

  // Halfword lane ignores off[0]; misalignment is only flagged, never realigned.
  assign sh_b = {in_off, 3'b000};
  assign sh_h = {in_off[OFF_W-1:1], 4'b0000};
  assign ld_b = 8'(in_word >> sh_b);
  assign ld_h = 16'(in_word >> sh_h);

  always_comb begin
    ext_dat = '0;
    ext_err = 1'b0;
    case (op_e'(in_op))
      OP_ZERO:   ext_dat = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      OP_SIGNED: ext_dat = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      OP_LUI:    ext_dat = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      OP_LB:     ext_dat = {{(DATA_W-8){ld_b[7]}}, ld_b};
      OP_LBU:    ext_dat = {{(DATA_W-8){1'b0}}, ld_b};
      OP_LH: begin
        ext_dat = {{(DATA_W-16){ld_h[15]}}, ld_h};
        ext_err = in_off[0];
      end
      OP_LHU: begin
        ext_dat = {{(DATA_W-16){1'b0}}, ld_h};
        ext_err = in_off[0];
      end
      default:   ext_err = 1'b1;
    endcase
  end

  logic [DEPTH:0]   rdy;
  logic             in_fire, out_fire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = reset && !flush && rdy[0];
  assign in_fire    = in_valid && in_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              vld_q, err_q;
    logic [DATA_W-1:0] dat_q;
    logic [TAG_W-1:0]  tag_q;
    logic              up_vld, up_err;
    logic [DATA_W-1:0] up_dat;
    logic [TAG_W-1:0]  up_tag;

    assign rdy[i] = !vld_q || rdy[i+1];

    if (i == 0) begin : g_head
      assign up_vld = in_fire;
      assign up_dat = ext_dat;
      assign up_tag = in_tag;
      assign up_err = ext_err;
    end else begin : g_body
      assign up_vld = g_stage[i-1].vld_q;
      assign up_dat = g_stage[i-1].dat_q;
      assign up_tag = g_stage[i-1].tag_q;
      assign up_err = g_stage[i-1].err_q;
    end

    // Payload only loads on a real transfer so a stalled head stays stable.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        tag_q <= '0;
        err_q <= 1'b0;
      end else if (flush) begin
        vld_q <= 1'b0;
      end else if (rdy[i]) begin
        vld_q <= up_vld;
        if (up_vld) begin
          dat_q <= up_dat;
          tag_q <= up_tag;
          err_q <= up_err;
        end
      end
    end
  end

  assign out_valid = g_stage[DEPTH-1].vld_q;
  assign out_data  = g_stage[DEPTH-1].dat_q;
  assign out_tag   = g_stage[DEPTH-1].tag_q;
  assign out_err   = g_stage[DEPTH-1].err_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CNT_W'(in_fire) - CNT_W'(out_fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed and random checks of ext_pipe with an expected-result queue per instance.
module tb_ext_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: 32-bit, depth 2
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [2:0]  a_in_op;
  logic [15:0] a_in_imm;
  logic [31:0] a_in_word, a_out_data;
  logic [1:0]  a_in_off, a_count;
  logic [4:0]  a_in_tag, a_out_tag;

  // Instance B: 64-bit, depth 1
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [2:0]  b_in_op;
  logic [15:0] b_in_imm;
  logic [63:0] b_in_word, b_out_data;
  logic [2:0]  b_in_off;
  logic [0:0]  b_count;
  logic [4:0]  b_in_tag, b_out_tag;

  ext_pipe #(.DATA_W(32), .IMM_W(16), .DEPTH(2), .TAG_W(5)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_imm(a_in_imm),
    .in_word(a_in_word), .in_off(a_in_off), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_err(a_out_err), .count(a_count)
  );

  ext_pipe #(.DATA_W(64), .IMM_W(16), .DEPTH(1), .TAG_W(5)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_imm(b_in_imm),
    .in_word(b_in_word), .in_off(b_in_off), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_err(b_out_err), .count(b_count)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   b_recv = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference for 64-bit lanes, written with indexed part-selects.
  function automatic exp_t ref_b(input logic [2:0] op, input logic [15:0] imm,
                                 input logic [63:0] word, input int off, input logic [4:0] tag);
    exp_t r;
    int   hb;
    r.d = '0;
    r.e = 1'b0;
    r.t = tag;
    hb  = off - (off % 2);
    case (op)
      3'd0: r.d = {48'h0, imm};
      3'd1: r.d = 64'($signed(imm));
      3'd2: r.d = {imm, 48'h0};
      3'd3: r.d = 64'($signed(word[off*8 +: 8]));
      3'd4: r.d = {56'h0, word[off*8 +: 8]};
      3'd5: begin r.d = 64'($signed(word[hb*8 +: 16])); r.e = (off % 2) == 1; end
      3'd6: begin r.d = {48'h0, word[hb*8 +: 16]};      r.e = (off % 2) == 1; end
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  // Output scoreboard for A, plus hold-stability of a stalled head.
  logic        a_prev_stall = 1'b0;
  logic [31:0] a_prev_d;
  logic [4:0]  a_prev_t;
  logic        a_prev_e;
  always @(negedge clk) begin
    if (!reset) begin
      a_prev_stall <= 1'b0;
    end else begin
      if (a_prev_stall) begin
        chk("hold_valid", 64'(a_out_valid), 64'd1);
        chk("hold_data",  64'(a_out_data), 64'(a_prev_d));
        chk("hold_tag",   64'(a_out_tag),  64'(a_prev_t));
        chk("hold_err",   64'(a_out_err),  64'(a_prev_e));
      end
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("spurious_a", 64'd1, 64'd0);
        else begin
          chk("a_data", 64'(a_out_data), qa[0].d);
          chk("a_tag",  64'(a_out_tag),  64'(qa[0].t));
          chk("a_err",  64'(a_out_err),  64'(qa[0].e));
          void'(qa.pop_front());
        end
      end
      a_prev_stall <= a_out_valid && !a_out_ready && !a_flush;
      a_prev_d     <= a_out_data;
      a_prev_t     <= a_out_tag;
      a_prev_e     <= a_out_err;
    end
  end

  always @(negedge clk) begin
    if (reset && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("spurious_b", 64'd1, 64'd0);
      else begin
        chk("b_data", b_out_data, qb[0].d);
        chk("b_tag",  64'(b_out_tag), 64'(qb[0].t));
        chk("b_err",  64'(b_out_err), 64'(qb[0].e));
        void'(qb.pop_front());
        b_recv++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] word,
                       input logic [1:0] off, input logic [4:0] tag);
    a_in_op = op; a_in_imm = imm; a_in_word = word; a_in_off = off; a_in_tag = tag;
    a_in_valid = 1'b1;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] word,
                        input logic [1:0] off, input logic [4:0] tag,
                        input logic [31:0] ed, input logic ee);
    int   n = 0;
    logic acc = 1'b0;
    set_a(op, imm, word, off, tag);
    while (!acc && n < 50) begin
      @(negedge clk);
      if (a_in_ready) begin
        acc = 1'b1;
        qa.push_back('{d: 64'(ed), t: tag, e: ee});
      end else begin
        step();
        n++;
      end
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    step();
    a_in_valid = 1'b0;
  endtask

  // Single op with out_ready=1: result must appear exactly two cycles after acceptance.
  task automatic send_lat(input logic [2:0] op, input logic [15:0] imm, input logic [4:0] tag,
                          input logic [31:0] ed, input logic ee);
    set_a(op, imm, 32'h0, 2'd0, tag);
    @(negedge clk);
    chk("lat_in_ready", 64'(a_in_ready), 64'd1);
    qa.push_back('{d: 64'(ed), t: tag, e: ee});
    step();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_invalid", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(a_out_valid), 64'd1);
    step();
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_a", 64'(qa.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent = 0;
    int   cyc = 0;
    int   max_cnt = 0;
    logic b_acc = 1'b0;
    exp_t e;

    reset = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    a_in_op = '0; a_in_imm = '0; a_in_word = '0; a_in_off = '0; a_in_tag = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_op = '0; b_in_imm = '0; b_in_word = '0; b_in_off = '0; b_in_tag = '0;

    #3;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  64'(a_out_data),  64'd0);
    chk("rst_out_tag",   64'(a_out_tag),   64'd0);
    chk("rst_out_err",   64'(a_out_err),   64'd0);
    chk("rst_count",     64'(a_count),     64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd0);
    @(posedge clk); #2 reset = 1'b1;
    step();

    // Modes and loads
    send_lat(3'd1, 16'h8001, 5'd1, 32'hFFFF8001, 1'b0);
    send_a(3'd0, 16'h8001, 32'h0, 2'd0, 5'd2, 32'h00008001, 1'b0);
    send_a(3'd2, 16'h8001, 32'h0, 2'd0, 5'd3, 32'h80010000, 1'b0);
    send_a(3'd7, 16'h8001, 32'h0, 2'd0, 5'd4, 32'h00000000, 1'b1);
    send_a(3'd3, 16'h0, 32'h80FF7F01, 2'd2, 5'd5, 32'hFFFFFFFF, 1'b0);
    send_a(3'd4, 16'h0, 32'h80FF7F01, 2'd3, 5'd6, 32'h00000080, 1'b0);
    send_a(3'd5, 16'h0, 32'h80FF7F01, 2'd2, 5'd7, 32'hFFFF80FF, 1'b0);
    send_a(3'd6, 16'h0, 32'h80FF7F01, 2'd0, 5'd8, 32'h00007F01, 1'b0);
    send_a(3'd5, 16'h0, 32'h80FF7F01, 2'd1, 5'd9, 32'h00007F01, 1'b1);
    drain_a();

    // Backpressure
    a_out_ready = 1'b0;
    send_a(3'd0, 16'h0011, 32'h0, 2'd0, 5'd1, 32'h00000011, 1'b0);
    send_a(3'd0, 16'h0022, 32'h0, 2'd0, 5'd2, 32'h00000022, 1'b0);
    set_a(3'd0, 16'h0033, 32'h0, 2'd0, 5'd3);
    @(negedge clk);
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp_count",    64'(a_count),    64'd2);
    chk("bp_head_tag", 64'(a_out_tag),  64'd1);
    repeat (3) step();
    a_out_ready = 1'b1;
    send_a(3'd0, 16'h0033, 32'h0, 2'd0, 5'd3, 32'h00000033, 1'b0);
    send_a(3'd0, 16'h0044, 32'h0, 2'd0, 5'd4, 32'h00000044, 1'b0);
    @(negedge clk);
    chk("bp_stream_tag3", {58'h0, a_out_valid, a_out_tag}, 64'h23);
    step();
    @(negedge clk);
    chk("bp_stream_tag4", {58'h0, a_out_valid, a_out_tag}, 64'h24);
    step();
    drain_a();

    // Flush with two in flight and a new op offered
    a_out_ready = 1'b0;
    send_a(3'd0, 16'h0005, 32'h0, 2'd0, 5'd5, 32'h5, 1'b0);
    send_a(3'd0, 16'h0006, 32'h0, 2'd0, 5'd6, 32'h6, 1'b0);
    set_a(3'd0, 16'h0009, 32'h0, 2'd0, 5'd9);
    a_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(a_in_ready), 64'd0);
    qa.delete();
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("flush_count",     64'(a_count),     64'd0);
    chk("flush_out_valid", 64'(a_out_valid), 64'd0);
    step();
    a_out_ready = 1'b1;
    repeat (4) step();

    // Asynchronous reset mid-stream
    send_a(3'd0, 16'h000A, 32'h0, 2'd0, 5'd10, 32'hA, 1'b0);
    send_a(3'd0, 16'h000B, 32'h0, 2'd0, 5'd11, 32'hB, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst_count",     64'(a_count),     64'd0);
    qa.delete();
    @(posedge clk); #2 reset = 1'b1;
    step();
    send_lat(3'd2, 16'h1234, 5'd12, 32'h12340000, 1'b0);
    drain_a();

    // Instance B: random stream with random backpressure
    while ((sent < 100 || qb.size() != 0) && cyc < 3000) begin
      step();
      cyc++;
      b_out_ready = 1'($urandom_range(0, 1));
      if (b_acc) begin
        b_in_valid = 1'b0;
        b_acc = 1'b0;
      end
      if (!b_in_valid && sent < 100) begin
        b_in_op   = 3'($urandom_range(0, 7));
        b_in_imm  = 16'($urandom);
        b_in_word = {$urandom, $urandom};
        b_in_off  = 3'($urandom_range(0, 7));
        b_in_tag  = 5'($urandom);
        b_in_valid = 1'b1;
      end
      @(negedge clk);
      if (int'(b_count) > max_cnt) max_cnt = int'(b_count);
      if (b_in_valid && b_in_ready) begin
        e = ref_b(b_in_op, b_in_imm, b_in_word, int'(b_in_off), b_in_tag);
        qb.push_back(e);
        sent++;
        b_acc = 1'b1;
      end
    end
    chk("b_sent",     64'(sent),       64'd100);
    chk("b_received", 64'(b_recv),     64'd100);
    chk("b_leftover", 64'(qb.size()),  64'd0);
    chk("b_max_count", 64'(max_cnt),   64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
